// File: rtl/buffer_pkg.sv
// Shared types and address helpers for the banked stream buffer.
package buffer_pkg;

  // Mode request driven on the state input.
  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_STORE  = 2'b01,
    MODE_STREAM = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // Internal controller state.
  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_STORE,
    FSM_STREAM,
    FSM_FINISH
  } fsm_e;

  // Bank holding a given word address (words interleave across banks).
  function automatic logic [31:0] bank_of(input logic [31:0] word_addr, input int unsigned banks);
    return word_addr % banks;
  endfunction

  // Row within the bank holding a given word address.
  function automatic logic [31:0] row_of(input logic [31:0] word_addr, input int unsigned banks);
    return word_addr / banks;
  endfunction

endpackage

// File: rtl/banked_stream_buffer_bank_ram.sv
// One bank of the stream buffer: simple dual-port RAM, registered read.
module bank_ram #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 1024,
  localparam int ROW_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ROW_W-1:0]  rd_row,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write port and one-cycle-latency read port; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_row] <= wr_data;
    if (rd_en) rd_data <= mem[rd_row];
  end

endmodule

// File: rtl/banked_stream_buffer.sv
// Multi-bank staging buffer: word-addressed loads, row-wide streaming with
// valid/ready backpressure through a 2-entry skid FIFO.
module banked_stream_buffer
  import buffer_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int BANKS  = 2,
  parameter int DEPTH  = 1024,
  // One guard bit above the buffer capacity so out-of-range writes are visible.
  localparam int ADDR_W = $clog2(BANKS*DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              state,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [WORD_W-1:0]       data_in,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [WORD_W*BANKS-1:0] data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    done,
  output logic                    overflow,
  output logic                    mode_err
);

  localparam int ROW_W = $clog2(DEPTH);
  localparam int PTR_W = ROW_W + 1;   // row pointers must hold DEPTH itself
  localparam int CAP   = BANKS * DEPTH;
  localparam int ROWB  = WORD_W * BANKS;

  mode_e mode;
  fsm_e  fsm_reg, fsm_next;

  logic [ADDR_W-1:0] hwm_reg;
  logic              overflow_reg, mode_err_reg, done_reg;
  logic [PTR_W-1:0]  rd_ptr_reg, pop_row_reg, row_end_reg, inflight_row_reg;
  logic              inflight_reg;
  logic [ROWB-1:0]   skid_data_reg [2];
  logic              skid_head_reg;
  logic [1:0]        skid_count_reg;

  logic              streaming, entering, pop, last_pop, stream_empty, done_next, issue;
  logic              wr_fire, wr_commit, skid_tail;
  logic [2:0]        occupancy;
  logic [ROWB-1:0]   row_word;
  logic [WORD_W-1:0] rd_word [BANKS];
  logic [BANKS-1:0]  wr_en_bank;

  assign mode         = mode_e'(state);
  assign wr_ready     = (fsm_reg == FSM_STORE);
  assign wr_fire      = wr_valid && wr_ready;
  assign wr_commit    = wr_fire && (addr < ADDR_W'(CAP));
  assign streaming    = (fsm_reg == FSM_STREAM) && (mode == MODE_STREAM);
  assign out_valid    = (skid_count_reg != 2'd0);
  assign data_out     = skid_data_reg[skid_head_reg];
  assign done         = done_reg;
  assign overflow     = overflow_reg;
  assign mode_err     = mode_err_reg;
  assign pop          = out_valid && out_ready && streaming;
  assign stream_empty = (pop_row_reg >= row_end_reg);
  assign last_pop     = pop && ((pop_row_reg + PTR_W'(1)) == row_end_reg);
  assign done_next    = streaming && (stream_empty || last_pop);
  // A slot is reserved per queued beat and per outstanding read; a pop frees one this cycle.
  assign occupancy    = {1'b0, skid_count_reg} + {2'b00, inflight_reg};
  assign issue        = streaming && (rd_ptr_reg < row_end_reg) && (occupancy < (3'd2 + {2'b00, pop}));
  assign skid_tail    = skid_head_reg ^ skid_count_reg[0];
  assign entering     = (fsm_reg != FSM_STREAM) && (fsm_next == FSM_STREAM);

  genvar gi;
  generate
    for (gi = 0; gi < BANKS; gi++) begin : g_bank
      logic [ADDR_W:0] slot_addr;

      assign wr_en_bank[gi] = wr_commit && (bank_of(32'(addr), BANKS) == 32'(gi));

      bank_ram #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_bank[gi]),
        .wr_row  (ROW_W'(row_of(32'(addr), BANKS))),
        .wr_data (data_in),
        .rd_en   (issue),
        .rd_row  (rd_ptr_reg[ROW_W-1:0]),
        .rd_data (rd_word[gi])
      );

      // Slots at or above the high-water mark were never written: present them as zero.
      assign slot_addr = (ADDR_W+1)'(inflight_row_reg) * (ADDR_W+1)'(BANKS) + (ADDR_W+1)'(gi);
      assign row_word[gi*WORD_W +: WORD_W] = (slot_addr < {1'b0, hwm_reg}) ? rd_word[gi] : '0;
    end
  endgenerate

  // Mode decode: the mode input is obeyed every cycle; streaming ends in FINISH.
  always_comb begin
    fsm_next = fsm_reg;
    case (mode)
      MODE_IDLE:   fsm_next = FSM_IDLE;
      MODE_STORE:  fsm_next = FSM_STORE;
      MODE_STREAM: begin
        if (fsm_reg == FSM_STREAM) begin
          if (done_next) fsm_next = FSM_FINISH;
        end else if (fsm_reg != FSM_FINISH) begin
          fsm_next = FSM_STREAM;
        end
      end
      default:     fsm_next = FSM_IDLE;
    endcase
  end

  // Controller state, status flags and high-water mark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg      <= FSM_IDLE;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      mode_err_reg <= 1'b0;
      hwm_reg      <= '0;
    end else begin
      fsm_reg  <= fsm_next;
      done_reg <= done_next;
      if (mode == MODE_RSVD) mode_err_reg <= 1'b1;
      if (wr_fire && !wr_commit) overflow_reg <= 1'b1;
      if (wr_commit && ((addr + ADDR_W'(1)) > hwm_reg)) hwm_reg <= addr + ADDR_W'(1);
    end
  end

  // Read pointer, outstanding read tracking and the skid FIFO; any mode change flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg       <= '0;
      pop_row_reg      <= '0;
      row_end_reg      <= '0;
      inflight_row_reg <= '0;
      inflight_reg     <= 1'b0;
      skid_head_reg    <= 1'b0;
      skid_count_reg   <= 2'd0;
      for (int i = 0; i < 2; i++) skid_data_reg[i] <= '0;
    end else begin
      if (!streaming) begin
        inflight_reg   <= 1'b0;
        skid_count_reg <= 2'd0;
      end else begin
        inflight_reg <= issue;
        if (issue) begin
          rd_ptr_reg       <= rd_ptr_reg + PTR_W'(1);
          inflight_row_reg <= rd_ptr_reg;
        end
        if (inflight_reg) skid_data_reg[skid_tail] <= row_word;
        if (pop) begin
          skid_head_reg <= ~skid_head_reg;
          pop_row_reg   <= pop_row_reg + PTR_W'(1);
        end
        skid_count_reg <= skid_count_reg + {1'b0, inflight_reg} - {1'b0, pop};
      end
      if (entering) begin
        rd_ptr_reg  <= PTR_W'(row_of(32'(addr), BANKS));
        pop_row_reg <= PTR_W'(row_of(32'(addr), BANKS));
        row_end_reg <= PTR_W'(row_of(32'(hwm_reg) + 32'(BANKS - 1), BANKS));
      end
    end
  end

endmodule
